// File: rtl/signal_lamp_monitor_pkg.sv
// Shared definitions for the signal lamp monitor: aspect codes, lamp drive
// patterns, fault cause bit positions and the fault FSM state type.
package signal_lamp_monitor_pkg;

    localparam logic [1:0] CODE_RED     = 2'b00;
    localparam logic [1:0] CODE_YELLOW  = 2'b01;
    localparam logic [1:0] CODE_GREEN   = 2'b10;
    localparam logic [1:0] CODE_ILLEGAL = 2'b11;

    // Lamp drives are {R,Y,G}
    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_OFF    = 3'b000;

    localparam int CAUSE_CONFLICT = 0;
    localparam int CAUSE_ILLEGAL  = 1;
    localparam int CAUSE_SEQUENCE = 2;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FAULT  = 1'b1
    } mon_state_t;

    function automatic logic [2:0] decode_lamp(input logic [1:0] code);
        case (code)
            CODE_RED:    decode_lamp = LAMP_RED;
            CODE_YELLOW: decode_lamp = LAMP_YELLOW;
            CODE_GREEN:  decode_lamp = LAMP_GREEN;
            default:     decode_lamp = LAMP_OFF;
        endcase
    endfunction

endpackage

// File: rtl/signal_lamp_monitor_aspect_checker.sv
// Per-approach code pipeline (s1 newer, s2 older), yellow-run counter and
// the illegal-code / sequence / short-yellow checks on the s2->s1 edge.
module aspect_checker
    import signal_lamp_monitor_pkg::*;
#(
    parameter int MIN_YELLOW = 1,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [1:0] code_in,
    output logic [1:0] s1_code,
    output logic       illegal,
    output logic       seq_viol,
    output logic [2:0] lamp
);

    localparam logic [CNT_W-1:0] YMIN    = CNT_W'(MIN_YELLOW);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       s1_q, s1_d;
    logic [1:0]       s2_q, s2_d;
    logic [CNT_W-1:0] yrun_q, yrun_d;
    logic             codes_valid;

    // yrun saturates at MIN_YELLOW, so after each edge it is the length of s2's yellow run
    always_comb begin
        s1_d   = code_in;
        s2_d   = s1_q;
        yrun_d = '0;
        if (s1_q == CODE_YELLOW) begin
            yrun_d = (yrun_q < YMIN) ? yrun_q + CNT_ONE : yrun_q;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            s1_q   <= CODE_RED;
            s2_q   <= CODE_RED;
            yrun_q <= '0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            yrun_q <= yrun_d;
        end
    end

    // Edges touching an illegal code are reported only as illegal
    assign codes_valid = (s1_q != CODE_ILLEGAL) && (s2_q != CODE_ILLEGAL);
    assign illegal     = (s1_q == CODE_ILLEGAL);
    assign seq_viol    = codes_valid && (
                             ((s2_q == CODE_GREEN)  && (s1_q == CODE_RED))    ||
                             ((s2_q == CODE_YELLOW) && (s1_q == CODE_GREEN))  ||
                             ((s2_q == CODE_RED)    && (s1_q == CODE_YELLOW)) ||
                             ((s2_q == CODE_YELLOW) && (s1_q == CODE_RED) && (yrun_q < YMIN)));
    assign s1_code     = s1_q;
    assign lamp        = decode_lamp(s1_q);

endmodule

// File: rtl/signal_lamp_monitor.sv
// Decodes highway/country aspect codes to lamp drives and latches safety
// faults, forcing flashing red on both approaches until a qualified clear.
module signal_lamp_monitor
    import signal_lamp_monitor_pkg::*;
#(
    parameter int MIN_YELLOW = 1,
    parameter int FLASH_HALF = 4,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [1:0] hwy_code,
    input  logic [1:0] contry_code,
    input  logic       fault_clr,
    output logic [2:0] hwy_lamp,
    output logic [2:0] contry_lamp,
    output logic       fault,
    output logic [2:0] fault_cause
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLASH_HALF - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0] hwy_s1, contry_s1;
    logic       hwy_ill, contry_ill, hwy_seq, contry_seq;
    logic [2:0] hwy_dec, contry_dec;
    logic [2:0] viol;
    logic       clr_ok;

    mon_state_t       state_q, state_d;
    logic [2:0]       cause_q, cause_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic [2:0]       hwy_lamp_q, hwy_lamp_d;
    logic [2:0]       contry_lamp_q, contry_lamp_d;

    aspect_checker #(.MIN_YELLOW(MIN_YELLOW), .CNT_W(CNT_W)) u_hwy (
        .clk      (clk),
        .clr_n    (clr_n),
        .code_in  (hwy_code),
        .s1_code  (hwy_s1),
        .illegal  (hwy_ill),
        .seq_viol (hwy_seq),
        .lamp     (hwy_dec)
    );

    aspect_checker #(.MIN_YELLOW(MIN_YELLOW), .CNT_W(CNT_W)) u_contry (
        .clk      (clk),
        .clr_n    (clr_n),
        .code_in  (contry_code),
        .s1_code  (contry_s1),
        .illegal  (contry_ill),
        .seq_viol (contry_seq),
        .lamp     (contry_dec)
    );

    // phase_q=1 means the red flash is lit
    always_comb begin
        viol                 = '0;
        viol[CAUSE_CONFLICT] = (hwy_s1 != CODE_RED) && (contry_s1 != CODE_RED);
        viol[CAUSE_ILLEGAL]  = hwy_ill | contry_ill;
        viol[CAUSE_SEQUENCE] = hwy_seq | contry_seq;
        clr_ok = fault_clr && (hwy_s1 == CODE_RED) && (contry_s1 == CODE_RED) && (viol == 3'b000);

        state_d       = state_q;
        cause_d       = cause_q;
        cnt_d         = cnt_q;
        phase_d       = phase_q;
        hwy_lamp_d    = hwy_lamp_q;
        contry_lamp_d = contry_lamp_q;

        case (state_q)
            ST_NORMAL: begin
                if (viol != 3'b000) begin
                    state_d       = ST_FAULT;
                    cause_d       = viol;
                    cnt_d         = '0;
                    phase_d       = 1'b1;
                    hwy_lamp_d    = LAMP_RED;
                    contry_lamp_d = LAMP_RED;
                end else begin
                    hwy_lamp_d    = hwy_dec;
                    contry_lamp_d = contry_dec;
                end
            end
            ST_FAULT: begin
                if (clr_ok) begin
                    state_d       = ST_NORMAL;
                    cause_d       = '0;
                    cnt_d         = '0;
                    phase_d       = 1'b1;
                    hwy_lamp_d    = LAMP_RED;
                    contry_lamp_d = LAMP_RED;
                end else begin
                    cause_d = cause_q | viol;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        phase_d = ~phase_q;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                    hwy_lamp_d    = phase_d ? LAMP_RED : LAMP_OFF;
                    contry_lamp_d = phase_d ? LAMP_RED : LAMP_OFF;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q       <= ST_NORMAL;
            cause_q       <= '0;
            cnt_q         <= '0;
            phase_q       <= 1'b1;
            hwy_lamp_q    <= LAMP_RED;
            contry_lamp_q <= LAMP_RED;
        end else begin
            state_q       <= state_d;
            cause_q       <= cause_d;
            cnt_q         <= cnt_d;
            phase_q       <= phase_d;
            hwy_lamp_q    <= hwy_lamp_d;
            contry_lamp_q <= contry_lamp_d;
        end
    end

    assign hwy_lamp    = hwy_lamp_q;
    assign contry_lamp = contry_lamp_q;
    assign fault       = (state_q == ST_FAULT);
    assign fault_cause = cause_q;

endmodule

// File: tb/tb_signal_lamp_monitor.sv
// Bench for signal_lamp_monitor: two instances (MIN_YELLOW=1/FLASH_HALF=4 and
// MIN_YELLOW=2/FLASH_HALF=3) driven in parallel, checked against a history-based model.
module tb_signal_lamp_monitor;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic [1:0] hwy_code = 2'b00;
    logic [1:0] contry_code = 2'b00;
    logic       fault_clr = 1'b0;
    logic [2:0] hl_o [2];
    logic [2:0] cl_o [2];
    logic [2:0] cause_o [2];
    logic       fault_o [2];

    signal_lamp_monitor #(.MIN_YELLOW(1), .FLASH_HALF(4), .CNT_W(8)) dut_a (
        .clk(clk), .clr_n(clr_n), .hwy_code(hwy_code), .contry_code(contry_code),
        .fault_clr(fault_clr), .hwy_lamp(hl_o[0]), .contry_lamp(cl_o[0]),
        .fault(fault_o[0]), .fault_cause(cause_o[0])
    );

    signal_lamp_monitor #(.MIN_YELLOW(2), .FLASH_HALF(3), .CNT_W(8)) dut_b (
        .clk(clk), .clr_n(clr_n), .hwy_code(hwy_code), .contry_code(contry_code),
        .fault_clr(fault_clr), .hwy_lamp(hl_o[1]), .contry_lamp(cl_o[1]),
        .fault(fault_o[1]), .fault_cause(cause_o[1])
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int inst, input logic [2:0] got, input logic [2:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d @%0t: got %b expected %b", name, inst, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Codes applied at past edges (oldest first); entries before reset count as RED.
    int         hq [$];
    int         cq [$];
    bit         m_fault [2];
    logic [2:0] m_cause [2];
    int         m_n [2];
    logic [2:0] m_hl [2];
    logic [2:0] m_cl [2];

    function automatic int miny_of(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    function automatic int fh_of(input int i);
        return (i == 0) ? 4 : 3;
    endfunction

    function automatic logic [2:0] lamp_of(input int code);
        case (code)
            0: return 3'b100;
            1: return 3'b010;
            2: return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    // Yellow cycles ending at the second-newest history entry, capped at miny.
    function automatic int yrun_of(input bit is_c, input int miny);
        int cnt = 0;
        int idx = (is_c ? cq.size() : hq.size()) - 2;
        while (idx >= 0 && cnt < miny && (is_c ? cq[idx] : hq[idx]) == 1) begin
            cnt++;
            idx--;
        end
        return cnt;
    endfunction

    function automatic bit bad_step(input int prev, input int cur, input int yr, input int miny);
        if (prev == 3 || cur == 3) return 1'b0;
        return (prev == 2 && cur == 0) || (prev == 1 && cur == 2) ||
               (prev == 0 && cur == 1) || (prev == 1 && cur == 0 && yr < miny);
    endfunction

    task automatic reset_model();
        hq.delete();
        cq.delete();
        repeat (3) begin
            hq.push_back(0);
            cq.push_back(0);
        end
        for (int i = 0; i < 2; i++) begin
            m_fault[i] = 1'b0;
            m_cause[i] = 3'b000;
            m_n[i]     = 0;
            m_hl[i]    = 3'b100;
            m_cl[i]    = 3'b100;
        end
    endtask

    task automatic model_edge(input int h, input int c, input bit clr);
        int h1 = hq[hq.size()-1];
        int h2 = hq[hq.size()-2];
        int c1 = cq[cq.size()-1];
        int c2 = cq[cq.size()-2];
        logic [2:0] v;
        for (int i = 0; i < 2; i++) begin
            v    = 3'b000;
            v[0] = (h1 != 0) && (c1 != 0);
            v[1] = (h1 == 3) || (c1 == 3);
            v[2] = bad_step(h2, h1, yrun_of(1'b0, miny_of(i)), miny_of(i)) ||
                   bad_step(c2, c1, yrun_of(1'b1, miny_of(i)), miny_of(i));
            if (!m_fault[i]) begin
                if (v != 3'b000) begin
                    m_fault[i] = 1'b1;
                    m_cause[i] = v;
                    m_n[i]     = 0;
                    m_hl[i]    = 3'b100;
                    m_cl[i]    = 3'b100;
                end else begin
                    m_hl[i] = lamp_of(h1);
                    m_cl[i] = lamp_of(c1);
                end
            end else if (v == 3'b000 && clr && h1 == 0 && c1 == 0) begin
                m_fault[i] = 1'b0;
                m_cause[i] = 3'b000;
                m_hl[i]    = 3'b100;
                m_cl[i]    = 3'b100;
            end else begin
                m_cause[i] = m_cause[i] | v;
                m_n[i]++;
                m_hl[i] = (((m_n[i] / fh_of(i)) % 2) == 0) ? 3'b100 : 3'b000;
                m_cl[i] = m_hl[i];
            end
        end
        hq.push_back(h);
        cq.push_back(c);
        if (hq.size() > 8) begin
            void'(hq.pop_front());
            void'(cq.pop_front());
        end
    endtask

    task automatic check_model();
        for (int i = 0; i < 2; i++) begin
            chk("hwy_lamp", i, hl_o[i], m_hl[i]);
            chk("contry_lamp", i, cl_o[i], m_cl[i]);
            chk("fault", i, {2'b00, fault_o[i]}, {2'b00, m_fault[i]});
            chk("fault_cause", i, cause_o[i], m_cause[i]);
        end
    endtask

    task automatic chk_reset_vals(input string name);
        for (int i = 0; i < 2; i++) begin
            chk({name, "_hwy"}, i, hl_o[i], 3'b100);
            chk({name, "_contry"}, i, cl_o[i], 3'b100);
            chk({name, "_fault"}, i, {2'b00, fault_o[i]}, 3'b000);
            chk({name, "_cause"}, i, cause_o[i], 3'b000);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the following negedge after checking.
    task automatic step(input int h, input int c, input bit clr);
        hwy_code    = h[1:0];
        contry_code = c[1:0];
        fault_clr   = clr;
        @(posedge clk);
        model_edge(h, c, clr);
        @(negedge clk);
        check_model();
    endtask

    // Asserts clr_n off-edge, checks reset values while random codes are applied, releases on RED.
    task automatic reset_phase(input string name, input int cycles);
        #2;
        clr_n = 1'b0;
        #1;
        chk_reset_vals(name);
        repeat (cycles) begin
            @(negedge clk);
            hwy_code    = 2'($urandom_range(0, 3));
            contry_code = 2'($urandom_range(0, 3));
            fault_clr   = 1'($urandom_range(0, 1));
            #1;
            chk_reset_vals(name);
        end
        @(negedge clk);
        hwy_code    = 2'b00;
        contry_code = 2'b00;
        fault_clr   = 1'b0;
        clr_n       = 1'b1;
        reset_model();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0] h;
        logic [1:0] c;
        logic       clr;
        logic [2:0] hl;
        logic [2:0] cl;
        logic       f;
        logic [2:0] cause;
    } vec_t;

    vec_t tbl [$];

    task automatic add(input logic [1:0] h, input logic [1:0] c, input logic clr,
                       input logic [2:0] hl, input logic [2:0] cl, input logic f, input logic [2:0] cause);
        vec_t v;
        v.h = h; v.c = c; v.clr = clr; v.hl = hl; v.cl = cl; v.f = f; v.cause = cause;
        tbl.push_back(v);
    endtask

    function automatic int adv(input int x);
        case (x)
            0: return 2;
            2: return 1;
            default: return 0;
        endcase
    endfunction

    initial begin
        int cur_h;
        int cur_c;
        int r;
        reset_model();

        // Legal cycle: lamps follow codes one edge behind the sampling edge (dut_a)
        add(2'd2, 2'd0, 0, 3'b100, 3'b100, 0, 3'b000);
        add(2'd2, 2'd0, 0, 3'b001, 3'b100, 0, 3'b000);
        add(2'd2, 2'd0, 0, 3'b001, 3'b100, 0, 3'b000);
        add(2'd2, 2'd0, 0, 3'b001, 3'b100, 0, 3'b000);
        add(2'd1, 2'd0, 0, 3'b001, 3'b100, 0, 3'b000);
        add(2'd0, 2'd0, 0, 3'b010, 3'b100, 0, 3'b000);
        add(2'd0, 2'd0, 0, 3'b100, 3'b100, 0, 3'b000);
        add(2'd0, 2'd2, 0, 3'b100, 3'b100, 0, 3'b000);
        add(2'd0, 2'd2, 0, 3'b100, 3'b001, 0, 3'b000);
        add(2'd0, 2'd2, 0, 3'b100, 3'b001, 0, 3'b000);
        add(2'd0, 2'd1, 0, 3'b100, 3'b001, 0, 3'b000);
        add(2'd0, 2'd0, 0, 3'b100, 3'b010, 0, 3'b000);
        add(2'd0, 2'd0, 0, 3'b100, 3'b100, 0, 3'b000);
        // Illegal contry code, then direct G->R while faulted, then qualified clear
        add(2'd0, 2'd3, 0, 3'b100, 3'b100, 0, 3'b000);
        add(2'd0, 2'd0, 0, 3'b100, 3'b100, 1, 3'b010);
        add(2'd2, 2'd0, 0, 3'b100, 3'b100, 1, 3'b010);
        add(2'd0, 2'd0, 0, 3'b100, 3'b100, 1, 3'b010);
        add(2'd0, 2'd0, 0, 3'b100, 3'b100, 1, 3'b110);
        add(2'd0, 2'd0, 1, 3'b100, 3'b100, 0, 3'b000);

        // Reset held with random codes, released on RED
        repeat (2) @(negedge clk);
        reset_phase("reset", 4);

        for (int k = 0; k < tbl.size(); k++) begin
            step(int'(tbl[k].h), int'(tbl[k].c), tbl[k].clr);
            chk($sformatf("tbl%0d_hwy", k), 0, hl_o[0], tbl[k].hl);
            chk($sformatf("tbl%0d_contry", k), 0, cl_o[0], tbl[k].cl);
            chk($sformatf("tbl%0d_fault", k), 0, {2'b00, fault_o[0]}, {2'b00, tbl[k].f});
            chk($sformatf("tbl%0d_cause", k), 0, cause_o[0], tbl[k].cause);
        end

        // One-cycle GREEN/GREEN conflict: cause 001, then 4 on / 4 off flashing
        step(2, 2, 0);
        chk("conflict_pre_fault", 0, {2'b00, fault_o[0]}, 3'b000);
        step(0, 0, 0);
        chk("conflict_fault", 0, {2'b00, fault_o[0]}, 3'b001);
        chk("conflict_cause", 0, cause_o[0], 3'b001);
        for (int n = 1; n < 14; n++) begin
            step(0, 0, 0);
            chk($sformatf("flash%0d", n), 0, hl_o[0], (((n / 4) % 2) == 0) ? 3'b100 : 3'b000);
        end
        // Mid-flash (lamps dark) async reset
        chk("flash_dark_before_reset", 0, hl_o[0], 3'b000);
        reset_phase("midflash_reset", 2);

        // Short yellow on dut_b (MIN_YELLOW=2), then a two-cycle yellow
        step(2, 0, 0); step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
        chk("short_yellow_b_cause", 1, cause_o[1], 3'b100);
        chk("short_yellow_a_fault", 0, {2'b00, fault_o[0]}, 3'b000);
        step(0, 0, 1);
        chk("short_yellow_b_clear", 1, {2'b00, fault_o[1]}, 3'b000);
        step(2, 0, 0); step(1, 0, 0); step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
        chk("long_yellow_b_fault", 1, {2'b00, fault_o[1]}, 3'b000);

        // Clear qualification while faulted
        step(0, 3, 0); step(0, 0, 0);
        chk("clrq_fault", 0, {2'b00, fault_o[0]}, 3'b001);
        step(2, 0, 0); step(2, 0, 1);
        chk("clr_while_green", 0, {2'b00, fault_o[0]}, 3'b001);
        step(1, 0, 0); step(1, 0, 0); step(0, 0, 0); step(0, 0, 1);
        chk("clr_ok_fault", 0, {2'b00, fault_o[0]}, 3'b000);
        chk("clr_ok_cause", 0, cause_o[0], 3'b000);
        chk("clr_ok_hwy", 0, hl_o[0], 3'b100);
        chk("clr_ok_contry", 0, cl_o[0], 3'b100);
        step(0, 3, 0); step(0, 0, 0);
        step(2, 0, 0); step(0, 0, 0); step(0, 0, 1);
        chk("clr_vs_sequence_fault", 0, {2'b00, fault_o[0]}, 3'b001);
        chk("clr_vs_sequence_cause", 0, cause_o[0], 3'b110);
        step(2, 2, 0); step(0, 0, 1);
        chk("clr_vs_conflict_fault", 0, {2'b00, fault_o[0]}, 3'b001);
        chk("clr_vs_conflict_cause", 0, cause_o[0], 3'b111);
        reset_phase("pre_random_reset", 1);

        // Random stream, mostly legal progressions with occasional junk codes
        cur_h = 0;
        cur_c = 0;
        for (int k = 0; k < 2000; k++) begin
            r = $urandom_range(0, 99);
            if (r >= 70 && r < 90) cur_h = adv(cur_h);
            else if (r >= 95) cur_h = $urandom_range(0, 3);
            r = $urandom_range(0, 99);
            if (r >= 70 && r < 90) cur_c = adv(cur_c);
            else if (r >= 96) cur_c = $urandom_range(0, 3);
            step(cur_h, cur_c, $urandom_range(0, 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
